// File: rtl/hxmpp_pkg.sv
// Shared definitions for the SSID scan controller.
// Holds the scan state encoding, the default table geometry and the
// SSID field widths ({x_pos, y_pos}).
package hxmpp_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int SSID_W_DEF = 8;
  localparam int X_W        = 4;
  localparam int Y_W        = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_LATCH   = 3'd2,
    ST_PRESENT = 3'd3,
    ST_DONE    = 3'd4
  } scan_state_t;

endpackage

// File: rtl/scan_addr_counter.sv
// Table address counter for the SSID scan.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset (count -> 0)
//   load          load load_value (takes priority over enable)
//   load_value    value loaded at the start of a scan
//   enable        advance the count by one
//   count         current table address
module scan_addr_counter #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_value,
  input  logic              enable,
  output logic [ADDR_W-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/ssid_scan_ctrl.sv
// SSID table scan controller.
// Walks an inclusive address range of a synchronous SSID table (one-cycle
// read latency), presenting each word on a valid/ready interface and
// counting accepted words.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   start, abort            scan request (IDLE only) / scan termination
//   first_addr, last_addr   inclusive scan range, sampled with start
//   rom_en, rom_addr        table read strobe and address
//   rom_data                table data, valid one cycle after rom_en
//   ssid, ssid_valid        presented SSID word, held until accepted
//   ssid_ready              consumer accept
//   busy                    scan in progress (any state but IDLE)
//   done                    one-cycle pulse after the last word is accepted
//   range_err               one-cycle pulse for a start with first > last
//   beat_count              words accepted in the current/last scan
module ssid_scan_ctrl
  import hxmpp_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int SSID_W = SSID_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [SSID_W-1:0] rom_data,
  output logic [SSID_W-1:0] ssid,
  output logic              ssid_valid,
  input  logic              ssid_ready,
  output logic              busy,
  output logic              done,
  output logic              range_err,
  output logic [ADDR_W:0]   beat_count
);

  scan_state_t       state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] last_q;
  logic              range_ok;
  logic              at_last;
  logic              cnt_load;
  logic              cnt_en;

  assign range_ok = (first_addr <= last_addr);
  assign at_last  = (addr == last_q);

  // The counter is only loaded/advanced on clock edges, so ssid_ready never
  // reaches rom_en or rom_addr combinationally.
  assign cnt_load = (state == ST_IDLE) && start && !abort && range_ok;
  assign cnt_en   = (state == ST_PRESENT) && ssid_ready && !abort && !at_last;
  assign rom_addr = addr;

  scan_addr_counter #(
    .ADDR_W(ADDR_W)
  ) u_addr_counter (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (cnt_load),
    .load_value(first_addr),
    .enable    (cnt_en),
    .count     (addr)
  );

  // Outputs are registered alongside the state: each branch sets the
  // strobe/valid values that belong to the state being entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      ssid       <= '0;
      beat_count <= '0;
      last_q     <= '0;
      rom_en     <= 1'b0;
      ssid_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      range_err  <= 1'b0;
    end else begin
      rom_en     <= 1'b0;
      ssid_valid <= 1'b0;
      done       <= 1'b0;
      range_err  <= 1'b0;
      // abort dominates any concurrent accept; beat_count is left as is.
      if (state != ST_IDLE && abort) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start && !abort) begin
              if (range_ok) begin
                last_q     <= last_addr;
                beat_count <= '0;
                state      <= ST_FETCH;
                rom_en     <= 1'b1;
                busy       <= 1'b1;
              end else begin
                range_err <= 1'b1;
              end
            end
          end
          ST_FETCH: begin
            state <= ST_LATCH;
          end
          ST_LATCH: begin
            ssid       <= rom_data;
            state      <= ST_PRESENT;
            ssid_valid <= 1'b1;
          end
          ST_PRESENT: begin
            if (ssid_ready) begin
              beat_count <= beat_count + 1'b1;
              // The last address is never incremented past, so a range
              // ending at the top of the table cannot wrap to 0.
              if (at_last) begin
                state <= ST_DONE;
                done  <= 1'b1;
              end else begin
                state  <= ST_FETCH;
                rom_en <= 1'b1;
              end
            end else begin
              ssid_valid <= 1'b1;
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ssid_scan_ctrl.sv
module tb_ssid_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] first_addr = 8'd0;
  logic [7:0] last_addr = 8'd0;
  logic       rom_en;
  logic [7:0] rom_addr;
  logic [7:0] rom_data = 8'd0;
  logic [7:0] ssid;
  logic       ssid_valid;
  logic       ssid_ready = 1'b0;
  logic       busy;
  logic       done;
  logic       range_err;
  logic [8:0] beat_count;

  ssid_scan_ctrl #(.ADDR_W(8), .SSID_W(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .abort     (abort),
    .first_addr(first_addr),
    .last_addr (last_addr),
    .rom_en    (rom_en),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .ssid      (ssid),
    .ssid_valid(ssid_valid),
    .ssid_ready(ssid_ready),
    .busy      (busy),
    .done      (done),
    .range_err (range_err),
    .beat_count(beat_count)
  );

  always #5 clk = ~clk;

  // Synchronous table: data appears the cycle after the read strobe.
  logic [7:0] rom [256];
  always @(posedge clk) if (rom_en) rom_data <= rom[rom_addr];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_seen = 0;
  int done_at = -1;
  int cur_first = 0;
  int cur_last = 0;
  int mode = 0;      // 0: ready tied 1, 1: random, 2: 4-cycle stall, 3: manual
  int stall = 0;
  int done0 = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Consumer ready generator.
  initial forever begin
    @(posedge clk);
    #1;
    case (mode)
      0: ssid_ready = 1'b1;
      1: ssid_ready = 1'($urandom_range(0, 1));
      2: begin
        if (ssid_valid) begin
          if (stall < 4) begin
            ssid_ready = 1'b0;
            stall++;
          end else begin
            ssid_ready = 1'b1;
          end
        end else begin
          ssid_ready = 1'b0;
          stall = 0;
        end
      end
      default: ;
    endcase
  end

  // Monitor: pops the expected word on every transfer.
  initial begin
    bit         hold_valid;
    logic [7:0] hold_ssid;
    logic [7:0] e;
    hold_valid = 0;
    hold_ssid = 8'd0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        hold_valid = 0;
      end else begin
        if (ssid_valid && hold_valid) check("ssid_hold", ssid, hold_ssid);
        if (rom_en)
          check("rom_addr_range", 32'(int'(rom_addr) >= cur_first && int'(rom_addr) <= cur_last), 1);
        if (done) begin
          done_seen++;
          check("done_timing", cyc, done_at);
          done_at = -1;
        end else if (done_at == cyc) begin
          check("done_missing", done, 1'b1);
          done_at = -1;
        end
        if (ssid_valid && ssid_ready && !abort) begin
          if (exp_q.size() == 0) begin
            check("unexpected_ssid", ssid_valid, 1'b0);
          end else begin
            e = exp_q.pop_front();
            check("ssid", ssid, e);
            if (exp_q.size() == 0) done_at = cyc + 1;
          end
          hold_valid = 0;
        end else if (ssid_valid) begin
          hold_valid = 1;
          hold_ssid = ssid;
        end else begin
          hold_valid = 0;
        end
      end
    end
  end

  task automatic do_start(input int f, input int l, input bit lat);
    @(posedge clk);
    #1;
    first_addr = 8'(f);
    last_addr = 8'(l);
    start = 1'b1;
    done0 = done_seen;
    if (f <= l) begin
      cur_first = f;
      cur_last = l;
      for (int a = f; a <= l; a++) exp_q.push_back(rom[a]);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    if (f <= l) begin
      check("start_busy", busy, 1'b1);
      check("start_beat_clr", beat_count, 0);
      if (lat) begin
        check("fetch_rom_en", rom_en, 1'b1);
        check("fetch_addr", rom_addr, f);
        @(posedge clk);
        #1;
        check("latch_rom_en", rom_en, 1'b0);
        check("latch_valid", ssid_valid, 1'b0);
        @(posedge clk);
        #1;
        check("present_valid", ssid_valid, 1'b1);
      end
    end else begin
      check("range_err", range_err, 1'b1);
      check("range_busy", busy, 1'b0);
    end
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (busy && n < max) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("wait_idle_timeout", busy, 1'b0);
  endtask

  task automatic wait_valid(input int max);
    int n = 0;
    while (!ssid_valid && n < max) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("wait_valid_timeout", ssid_valid, 1'b1);
  endtask

  task automatic finish_scan(input int beats);
    wait_idle(400);
    check("beat_count", beat_count, beats);
    check("done_once", done_seen - done0, 1);
    check("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    rom[0] = 8'h08; rom[1] = 8'h38; rom[2] = 8'h78; rom[3] = 8'h88;

    // Reset state
    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_rom_en", rom_en, 1'b0);
    check("rst_valid", ssid_valid, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_range_err", range_err, 1'b0);
    check("rst_ssid", ssid, 0);
    check("rst_beat", beat_count, 0);
    check("rst_addr", rom_addr, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Range 0..3, ready tied high
    mode = 0;
    do_start(0, 3, 1);
    finish_scan(4);

    // Single-entry range
    do_start(5, 5, 1);
    finish_scan(1);

    // Inverted range
    do_start(9, 3, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("range_err_pulse", range_err, 1'b0);
      check("range_no_busy", busy, 1'b0);
      check("range_no_rom_en", rom_en, 1'b0);
    end
    check("range_beat_kept", beat_count, 1);

    // Top of table with consumer stalls
    mode = 2;
    do_start(250, 255, 1);
    finish_scan(6);
    check("no_wrap_addr", rom_addr, 255);

    // abort + start together in IDLE
    mode = 3;
    ssid_ready = 1'b0;
    @(posedge clk);
    #1;
    first_addr = 8'd1; last_addr = 8'd2; start = 1'b1; abort = 1'b1;
    @(posedge clk);
    #1;
    check("abort_start_busy", busy, 1'b0);
    first_addr = 8'd9; last_addr = 8'd3;
    @(posedge clk);
    #1;
    start = 1'b0; abort = 1'b0;
    check("abort_start_rerr", range_err, 1'b0);

    // Abort in PRESENT of second beat, with ready high at the same time
    do_start(0, 7, 0);
    wait_valid(20);
    ssid_ready = 1'b1;
    @(posedge clk);
    #1;
    ssid_ready = 1'b0;
    wait_valid(20);
    abort = 1'b1;
    ssid_ready = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    ssid_ready = 1'b0;
    exp_q.delete();
    check("abort_idle", busy, 1'b0);
    check("abort_valid", ssid_valid, 1'b0);
    check("abort_beat", beat_count, 1);
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_done", done_seen - done0, 0);
    check("abort_beat_hold", beat_count, 1);

    // start while busy is ignored
    mode = 1;
    do_start(0, 3, 0);
    @(posedge clk);
    #1;
    first_addr = 8'd100; last_addr = 8'd120; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    finish_scan(4);

    // Asynchronous reset during LATCH
    mode = 0;
    do_start(10, 12, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    done_at = -1;
    check("arst_busy", busy, 1'b0);
    check("arst_rom_en", rom_en, 1'b0);
    check("arst_valid", ssid_valid, 1'b0);
    check("arst_ssid", ssid, 0);
    check("arst_beat", beat_count, 0);
    check("arst_addr", rom_addr, 0);
    check("arst_done", done, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    do_start(20, 22, 1);
    finish_scan(3);

    // Randomized scans
    mode = 1;
    for (int k = 0; k < 15; k++) begin
      int f;
      int l;
      for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
      f = $urandom_range(0, 255);
      l = f + $urandom_range(0, 5);
      if (l > 255) l = 255;
      do_start(f, l, k[0]);
      finish_scan(l - f + 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
